// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit with HI/LO result registers (MULT/MULTU/DIV/DIVU, MTHI/MTLO).
// Optional MDU_EARLY_EXIT_EN: multiplies finish as soon as the remaining multiplier bits are zero.
//   state | meaning
//   IDLE  | accept start or MTHI/MTLO writes
//   CALC  | one shift-add / shift-subtract step per cycle
//   FIX   | sign correction, write hi/lo, pulse done
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t             state;
  logic [CW-1:0]      count;
  logic               is_div, a_neg, b_neg, b_zero;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   rem;
`ifdef MDU_EARLY_EXIT_EN
  logic [WIDTH-1:0]   mrem;
`endif

  logic               sa, sb, neg_res, div_ok, last_step;
  logic [WIDTH-1:0]   abs_a, abs_b, a_orig, quo, remv, div_sub;
  logic [WIDTH:0]     mul_sum, div_shift;
  logic [WIDTH+1:0]   div_diff;
  logic [2*WIDTH-1:0] mul_next, prod_raw, prod;

  assign sa    = ~op[0] & A[WIDTH-1];
  assign sb    = ~op[0] & B[WIDTH-1];
  assign abs_a = sa ? -A : A;
  assign abs_b = sb ? -B : B;

  // Multiply: acc = {partial product, remaining multiplier}, shifted right each step.
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a_abs} : '0);
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};

  // Divide: acc[WIDTH-1:0] shifts dividend bits out and quotient bits in.
  assign div_shift = {rem, acc[WIDTH-1]};
  assign div_diff  = {1'b0, div_shift} - {2'b0, b_abs};
  assign div_ok    = ~div_diff[WIDTH+1];
  assign div_sub   = WIDTH'(div_shift - {1'b0, b_abs});

  assign neg_res = a_neg ^ b_neg;
  assign a_orig  = a_neg ? -a_abs : a_abs;
  assign quo     = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign remv    = a_neg ? -rem : rem;

`ifdef MDU_EARLY_EXIT_EN
  logic [CW-1:0] shamt;
  assign shamt     = CW'(WIDTH) - count;
  assign prod_raw  = acc >> shamt;
  assign last_step = (count == CW'(WIDTH - 1)) || (!is_div && (mrem[WIDTH-1:1] == '0));
`else
  assign prod_raw  = acc;
  assign last_step = (count == CW'(WIDTH - 1));
`endif
  assign prod = neg_res ? -prod_raw : prod_raw;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      count  <= '0;
      is_div <= 1'b0;
      a_neg  <= 1'b0;
      b_neg  <= 1'b0;
      b_zero <= 1'b0;
      a_abs  <= '0;
      b_abs  <= '0;
      acc    <= '0;
      rem    <= '0;
`ifdef MDU_EARLY_EXIT_EN
      mrem   <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            is_div <= op[1];
            a_neg  <= sa;
            b_neg  <= sb;
            b_zero <= (B == '0);
            a_abs  <= abs_a;
            b_abs  <= abs_b;
            acc    <= {{WIDTH{1'b0}}, (op[1] ? abs_a : abs_b)};
            rem    <= '0;
            count  <= '0;
`ifdef MDU_EARLY_EXIT_EN
            mrem   <= abs_b;
`endif
            busy   <= 1'b1;
            state  <= CALC;
          end else begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
          end
        end
        CALC: begin
          count <= count + 1'b1;
          if (is_div) begin
            rem             <= div_ok ? div_sub : div_shift[WIDTH-1:0];
            acc[WIDTH-1:0]  <= {acc[WIDTH-2:0], div_ok};
          end else begin
            acc <= mul_next;
          end
`ifdef MDU_EARLY_EXIT_EN
          mrem <= mrem >> 1;
`endif
          if (last_step) state <= FIX;
        end
        FIX: begin
          if (is_div) begin
            // Divide by zero: all-ones quotient, dividend passed through as remainder.
            if (b_zero) begin
              lo <= '1;
              hi <= a_orig;
            end else begin
              lo <= quo;
              hi <= remv;
            end
          end else begin
            {hi, lo} <= prod;
          end
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Directed testbench for mdu_iter; expected latency follows MDU_EARLY_EXIT_EN when defined.
module tb_mdu_iter;

`ifdef MDU_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn, start, hi_we, lo_we;
  logic [1:0]  op;
  logic [31:0] A, B, wdata;
  logic        busy, done;
  logic [31:0] hi, lo;

  int vecs = 0;
  int errs = 0;

  mdu_iter #(.WIDTH(32)) dut (
    .clk(clk), .rstn(rstn), .start(start), .op(op), .A(A), .B(B),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_lat(input logic [1:0] o, input logic [31:0] b);
    int steps;
    logic [31:0] m;
    if (!EARLY || o[1]) return 33;
    m = (!o[0] && b[31]) ? -b : b;
    steps = 1;
    for (int i = 0; i < 32; i++) if (m[i]) steps = i + 1;
    return steps + 1;
  endfunction

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int nbusy);
    op = o; A = a; B = b; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0; nbusy = 0;
    while (lat < 200) begin
      if (busy) nbusy++;
      tick();
      lat++;
      if (done) break;
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = 2'd0; A = '0; B = '0; wdata = '0;
    repeat (3) tick();
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b want 0", busy); end
    vecs++; if (done !== 1'b0) begin errs++; $display("FAIL reset_done: got %b want 0", done); end
    vecs++; if (hi !== 32'h0) begin errs++; $display("FAIL reset_hi: got %h want 0", hi); end
    vecs++; if (lo !== 32'h0) begin errs++; $display("FAIL reset_lo: got %h want 0", lo); end
    rstn = 1'b1;
    tick();
  endtask

  typedef struct {
    logic [1:0]  o;
    logic [31:0] a, b, h, l;
  } vec_t;

  task automatic test_ops();
    vec_t tbl[12];
    int lat, nb, el;
    tbl[0]  = '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    tbl[1]  = '{2'd1, 32'h00000005, 32'h00000001, 32'h00000000, 32'h00000005};
    tbl[2]  = '{2'd0, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
    tbl[3]  = '{2'd0, 32'hFFFFFFFD, 32'hFFFFFFF9, 32'h00000000, 32'h00000015};
    tbl[4]  = '{2'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    tbl[5]  = '{2'd3, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003};
    tbl[6]  = '{2'd2, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    tbl[7]  = '{2'd3, 32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF};
    tbl[8]  = '{2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    tbl[9]  = '{2'd2, 32'hFFFFEDCC, 32'h00000000, 32'hFFFFEDCC, 32'hFFFFFFFF};
    tbl[10] = '{2'd3, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF};
    tbl[11] = '{2'd1, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000};
    foreach (tbl[i]) begin
      run_op(tbl[i].o, tbl[i].a, tbl[i].b, lat, nb);
      el = exp_lat(tbl[i].o, tbl[i].b);
      vecs++; if (lat !== el) begin errs++; $display("FAIL vec%0d latency: got %0d want %0d", i, lat, el); end
      vecs++; if (nb !== el) begin errs++; $display("FAIL vec%0d busy_cycles: got %0d want %0d", i, nb, el); end
      vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL vec%0d busy_at_done: got %b want 0", i, busy); end
      vecs++; if (hi !== tbl[i].h) begin errs++; $display("FAIL vec%0d hi: got %h want %h", i, hi, tbl[i].h); end
      vecs++; if (lo !== tbl[i].l) begin errs++; $display("FAIL vec%0d lo: got %h want %h", i, lo, tbl[i].l); end
      tick();
      vecs++; if (done !== 1'b0) begin errs++; $display("FAIL vec%0d done_pulse: got %b want 0", i, done); end
    end
  endtask

  task automatic test_back_to_back();
    int lat, nb;
    run_op(2'd1, 32'd3, 32'd4, lat, nb);
    vecs++; if (lo !== 32'd12) begin errs++; $display("FAIL b2b_first_lo: got %h want %h", lo, 32'd12); end
    run_op(2'd3, 32'd100, 32'd7, lat, nb);
    vecs++; if (lat !== 33) begin errs++; $display("FAIL b2b_latency: got %0d want 33", lat); end
    vecs++; if (lo !== 32'd14) begin errs++; $display("FAIL b2b_lo: got %h want %h", lo, 32'd14); end
    vecs++; if (hi !== 32'd2) begin errs++; $display("FAIL b2b_hi: got %h want %h", hi, 32'd2); end
    tick();
  endtask

  task automatic test_ignore_busy();
    int lat, nb, n;
    run_op(2'd1, 32'd2, 32'd3, lat, nb);
    op = 2'd1; A = 32'd6; B = 32'hFFFFFFFF; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    start = 1'b1; op = 2'd2; A = 32'd99; B = 32'd3;
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEADBEEF;
    tick();
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    vecs++; if (hi !== 32'h0) begin errs++; $display("FAIL ign_hi_stable: got %h want 0", hi); end
    vecs++; if (lo !== 32'd6) begin errs++; $display("FAIL ign_lo_stable: got %h want %h", lo, 32'd6); end
    n = 0;
    while (!done && n < 100) begin tick(); n++; end
    vecs++; if (done !== 1'b1) begin errs++; $display("FAIL ign_done_timeout: got %b want 1", done); end
    // 6 * 0xFFFFFFFF = 0x5_FFFFFFFA
    vecs++; if (hi !== 32'h5) begin errs++; $display("FAIL ign_hi: got %h want %h", hi, 32'h5); end
    vecs++; if (lo !== 32'hFFFFFFFA) begin errs++; $display("FAIL ign_lo: got %h want %h", lo, 32'hFFFFFFFA); end
    tick();
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL ign_no_restart: got %b want 0", busy); end
  endtask

  task automatic test_mthi_mtlo();
    int n;
    lo_we = 1'b1; wdata = 32'hA5A5A5A5;
    tick();
    lo_we = 1'b0;
    vecs++; if (lo !== 32'hA5A5A5A5) begin errs++; $display("FAIL mtlo_lo: got %h want %h", lo, 32'hA5A5A5A5); end
    vecs++; if (hi !== 32'h5) begin errs++; $display("FAIL mtlo_hi_kept: got %h want %h", hi, 32'h5); end
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h12345678;
    tick();
    hi_we = 1'b0; lo_we = 1'b0;
    vecs++; if (hi !== 32'h12345678) begin errs++; $display("FAIL mtboth_hi: got %h want %h", hi, 32'h12345678); end
    vecs++; if (lo !== 32'h12345678) begin errs++; $display("FAIL mtboth_lo: got %h want %h", lo, 32'h12345678); end
    op = 2'd1; A = 32'd3; B = 32'd3; start = 1'b1; hi_we = 1'b1; wdata = 32'hFFFF0000;
    tick();
    start = 1'b0; hi_we = 1'b0;
    vecs++; if (hi !== 32'h12345678) begin errs++; $display("FAIL start_wins_hi: got %h want %h", hi, 32'h12345678); end
    vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL start_wins_busy: got %b want 1", busy); end
    n = 0;
    while (!done && n < 100) begin tick(); n++; end
    vecs++; if (hi !== 32'h0) begin errs++; $display("FAIL start_wins_res_hi: got %h want 0", hi); end
    vecs++; if (lo !== 32'd9) begin errs++; $display("FAIL start_wins_res_lo: got %h want %h", lo, 32'd9); end
    tick();
  endtask

  task automatic test_reset_mid();
    int ndone;
    op = 2'd1; A = 32'h01234567; B = 32'hFFFFFFFF; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (11) tick();
    vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL midrst_pre_busy: got %b want 1", busy); end
    rstn = 1'b0;
    #1;
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL midrst_busy: got %b want 0", busy); end
    vecs++; if (hi !== 32'h0) begin errs++; $display("FAIL midrst_hi: got %h want 0", hi); end
    vecs++; if (lo !== 32'h0) begin errs++; $display("FAIL midrst_lo: got %h want 0", lo); end
    repeat (2) tick();
    rstn = 1'b1;
    ndone = 0;
    repeat (40) begin
      tick();
      if (done) ndone++;
    end
    vecs++; if (ndone !== 0) begin errs++; $display("FAIL midrst_no_done: got %0d want 0", ndone); end
    vecs++; if (lo !== 32'h0) begin errs++; $display("FAIL midrst_lo_after: got %h want 0", lo); end
  endtask

  initial begin
    test_reset();
    test_ops();
    test_back_to_back();
    test_ignore_busy();
    test_mthi_mtlo();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
